dma_priority_arbiter: RTL and testbench

//  Priority resolver and bus-request sequencer for the 4-channel DMA controller.

---
 rtl/dma_priority_arbiter.sv | 150 +++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
// Priority resolver and bus-request sequencer for a 4-channel DMA controller.
// Define DMA_DREQ_SYNC_EN to add a 2-flop synchronizer on the DREQ inputs.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        commandReg,
    input  logic [7:0]        requestReg,
    input  logic [7:0]        maskReg,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic              svcDone,
    output logic              HRQ,
    output logic              grantValid,
    output logic [NUM_CH-1:0] chGrant,
    output logic [1:0]        chSel,
    output logic [NUM_CH-1:0] pendReq
);

    typedef enum logic [1:0] {IDLE, REQ, GRANT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NUM_CH-1:0] dreq_in;
    logic [NUM_CH-1:0] eff;
    logic              any_req;
    logic [1:0]        low_pri;
    logic [1:0]        low_pri_nxt;
    logic [1:0]        cand;
    logic [1:0]        win_sel;
    logic              win_found;
    logic              hrq_nxt;
    logic              gv_nxt;
    logic [NUM_CH-1:0] grant_nxt;
    logic [1:0]        sel_nxt;
    logic              unused_bits;

    assign unused_bits = ^{commandReg[7], commandReg[5], commandReg[3], commandReg[1:0],
                           requestReg[7:4], maskReg[7:4]};

`ifdef DMA_DREQ_SYNC_EN
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;

    // Synchronizer resets to 0 regardless of the configured DREQ polarity.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= DREQ;
            sync2 <= sync1;
        end
    end

    assign dreq_in = sync2;
`else
    assign dreq_in = DREQ;
`endif

    // Software requests bypass the mask; hardware requests honour polarity and mask.
    assign eff     = ((dreq_in ^ {NUM_CH{commandReg[6]}}) & ~maskReg[NUM_CH-1:0])
                     | requestReg[NUM_CH-1:0];
    assign any_req = |eff;

    // Scan channels from highest to lowest priority; rotating mode starts after lowPri.
    always_comb begin
        win_sel   = 2'd0;
        win_found = 1'b0;
        cand      = 2'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = commandReg[4] ? (low_pri + 2'(k + 1)) : 2'(k);
            if (!win_found && eff[cand]) begin
                win_sel   = cand;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            HRQ        <= 1'b0;
            grantValid <= 1'b0;
            chGrant    <= '0;
            chSel      <= 2'd0;
            pendReq    <= '0;
            low_pri    <= 2'd3;
        end else begin
            state      <= state_nxt;
            HRQ        <= hrq_nxt;
            grantValid <= gv_nxt;
            chGrant    <= grant_nxt;
            chSel      <= sel_nxt;
            pendReq    <= eff;
            low_pri    <= low_pri_nxt;
        end
    end

    // Once granted, only svcDone or a falling HLDA ends the service.
    always_comb begin
        state_nxt   = state;
        hrq_nxt     = HRQ;
        gv_nxt      = grantValid;
        grant_nxt   = chGrant;
        sel_nxt     = chSel;
        low_pri_nxt = low_pri;
        case (state)
            IDLE: begin
                if (any_req && !commandReg[2]) begin
                    hrq_nxt   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (HLDA) begin
                    if (any_req) begin
                        gv_nxt    = 1'b1;
                        grant_nxt = NUM_CH'(1) << win_sel;
                        sel_nxt   = win_sel;
                        state_nxt = GRANT;
                    end else begin
                        hrq_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end else if (!any_req || commandReg[2]) begin
                    hrq_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (svcDone || !HLDA) begin
                    if (svcDone && commandReg[4]) begin
                        low_pri_nxt = chSel;
                    end
                    hrq_nxt   = 1'b0;
                    gv_nxt    = 1'b0;
                    grant_nxt = '0;
                    sel_nxt   = 2'd0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Randomized and directed bench for dma_priority_arbiter with a queue-based
// scoreboard fed by a cycle-level behavioural model.
module tb_dma_priority_arbiter;

    logic       CLK;
    logic       RESET;
    logic [7:0] commandReg;
    logic [7:0] requestReg;
    logic [7:0] maskReg;
    logic [3:0] DREQ;
    logic       HLDA;
    logic       svcDone;
    logic       HRQ;
    logic       grantValid;
    logic [3:0] chGrant;
    logic [1:0] chSel;
    logic [3:0] pendReq;

    dma_priority_arbiter dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .commandReg (commandReg),
        .requestReg (requestReg),
        .maskReg    (maskReg),
        .DREQ       (DREQ),
        .HLDA       (HLDA),
        .svcDone    (svcDone),
        .HRQ        (HRQ),
        .grantValid (grantValid),
        .chGrant    (chGrant),
        .chSel      (chSel),
        .pendReq    (pendReq)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [11:0] exp_q[$];
    bit          done     = 0;

    // Model state: phase 0 = idle, 1 = waiting for HLDA, 2 = serving a channel.
    int         m_phase;
    logic       m_hrq;
    logic       m_gv;
    logic [3:0] m_grant;
    int         m_sel;
    int         m_low;
    logic [3:0] m_pend;
    logic [3:0] m_d1;
    logic [3:0] m_d2;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [11:0] actual,
                                input logic [11:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got hrq/gv/grant/sel/pend=%03h required %03h at %0t",
                     name, actual, expected, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_hrq   = 1'b0;
        m_gv    = 1'b0;
        m_grant = 4'b0;
        m_sel   = 0;
        m_low   = 3;
        m_pend  = 4'b0;
        m_d1    = 4'b0;
        m_d2    = 4'b0;
    endtask

    task automatic model_step(input logic rst, input logic [7:0] cmd, input logic [7:0] req,
                              input logic [7:0] mask, input logic [3:0] dreq,
                              input logic hlda, input logic svc);
        logic [3:0] used;
        logic [3:0] eff;
        int         cand;
        int         win;
        if (!rst) begin
            model_reset();
        end else begin
`ifdef DMA_DREQ_SYNC_EN
            used = m_d2;
            m_d2 = m_d1;
            m_d1 = dreq;
`else
            used = dreq;
`endif
            eff = ((used ^ {4{cmd[6]}}) & ~mask[3:0]) | req[3:0];
            win = -1;
            for (int k = 0; k < 4; k++) begin
                cand = cmd[4] ? (m_low + 1 + k) % 4 : k;
                if (win < 0 && eff[cand]) win = cand;
            end
            m_pend = eff;
            if (m_phase == 0) begin
                if (eff != 0 && !cmd[2]) begin
                    m_hrq   = 1'b1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (hlda && eff != 0) begin
                    m_gv    = 1'b1;
                    m_sel   = win;
                    m_grant = 4'(1 << win);
                    m_phase = 2;
                end else if (hlda || eff == 0 || cmd[2]) begin
                    m_hrq   = 1'b0;
                    m_phase = 0;
                end
            end else begin
                if (svc || !hlda) begin
                    if (svc && cmd[4]) m_low = m_sel;
                    m_hrq   = 1'b0;
                    m_gv    = 1'b0;
                    m_grant = 4'b0;
                    m_sel   = 0;
                    m_phase = 0;
                end
            end
        end
        exp_q.push_back({m_hrq, m_gv, m_grant, 2'(m_sel), m_pend});
    endtask

    // Inputs change half a cycle before the edge; the expected result is queued at once.
    task automatic apply_stimulus(input logic rst, input logic [7:0] cmd, input logic [7:0] req,
                                  input logic [7:0] mask, input logic [3:0] dreq,
                                  input logic hlda, input logic svc);
        @(negedge CLK);
        #1;
        RESET      = rst;
        commandReg = cmd;
        requestReg = req;
        maskReg    = mask;
        DREQ       = dreq;
        HLDA       = hlda;
        svcDone    = svc;
        model_step(rst, cmd, req, mask, dreq, hlda, svc);
    endtask

    task automatic serve(input logic [7:0] cmd, input logic [7:0] req,
                         input logic [7:0] mask, input logic [3:0] dreq);
        apply_stimulus(1'b1, cmd, req, mask, dreq, 1'b0, 1'b0);
        apply_stimulus(1'b1, cmd, req, mask, dreq, 1'b1, 1'b0);
        apply_stimulus(1'b1, cmd, req, mask, dreq, 1'b1, 1'b0);
        apply_stimulus(1'b1, cmd, req, mask, dreq, 1'b1, 1'b1);
        apply_stimulus(1'b1, cmd, req, mask, dreq, 1'b0, 1'b0);
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0)
                check_output("cycle", {HRQ, grantValid, chGrant, chSel, pendReq},
                             exp_q.pop_front());
        end
    end

    initial begin
        logic [7:0] cmd;
        logic [7:0] mask;
        logic [7:0] req;
        logic [3:0] dreq;
        logic       hlda;
        logic       svc;

        RESET      = 1'b1;
        commandReg = 8'h00;
        requestReg = 8'h00;
        maskReg    = 8'h00;
        DREQ       = 4'h0;
        HLDA       = 1'b0;
        svcDone    = 1'b0;
        model_reset();
        #2 RESET = 1'b0;
        #1 check_output("reset_state", {HRQ, grantValid, chGrant, chSel, pendReq}, 12'h000);
        apply_stimulus(1'b0, 8'h00, 8'h00, 8'h00, 4'hF, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);

        // Fixed priority, rotating sequence, masking, polarity.
        serve(8'h00, 8'h00, 8'h00, 4'b1010);
        serve(8'h10, 8'h00, 8'h00, 4'b0110);
        serve(8'h10, 8'h00, 8'h00, 4'b0110);
        serve(8'h10, 8'h00, 8'h00, 4'b1111);
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, 8'h00, 8'h00, 8'h0F, 4'hF, 1'b1, 1'b0);
        serve(8'h00, 8'h04, 8'h0F, 4'hF);
        serve(8'h40, 8'h00, 8'h00, 4'b1110);

        // Abort by dropping HLDA, then re-request; svcDone and HLDA fall together.
        apply_stimulus(1'b1, 8'h10, 8'h00, 8'h00, 4'b1001, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h10, 8'h00, 8'h00, 4'b1001, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'h10, 8'h00, 8'h00, 4'b1001, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h10, 8'h00, 8'h00, 4'b1001, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h10, 8'h00, 8'h00, 4'b1001, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'h10, 8'h00, 8'h00, 4'b1001, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h10, 8'h00, 8'h00, 4'b1001, 1'b0, 1'b0);

        // Reset in the middle of a grant, then confirm lowPri went back to 3.
        apply_stimulus(1'b1, 8'h10, 8'h00, 8'h00, 4'hF, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h10, 8'h00, 8'h00, 4'hF, 1'b1, 1'b0);
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1 check_output("async_reset", {HRQ, grantValid, chGrant, chSel, pendReq}, 12'h000);
        model_reset();
        apply_stimulus(1'b0, 8'h10, 8'h00, 8'h00, 4'hF, 1'b1, 1'b0);
        serve(8'h10, 8'h00, 8'h00, 4'hF);

        cmd = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            if (i % 48 == 0) begin
                cmd = 8'($urandom);
                cmd[2] = ($urandom_range(0, 7) == 0);
            end
            mask = 8'($urandom & $urandom & $urandom);
            req  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom & 32'hF0);
            dreq = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            if (m_phase == 2) begin
                hlda = ($urandom_range(0, 15) != 0);
                svc  = ($urandom_range(0, 3) == 0);
            end else if (m_phase == 1) begin
                hlda = ($urandom_range(0, 2) == 0);
                svc  = ($urandom_range(0, 15) == 0);
            end else begin
                hlda = ($urandom_range(0, 7) == 0);
                svc  = ($urandom_range(0, 15) == 0);
            end
            apply_stimulus(1'b1, cmd, req, mask, dreq, hlda, svc);
        end

        @(posedge CLK);
        #3;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL drain: got %0d pending entries required 0", exp_q.size());
        end
        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
